// File: rtl/fir3_pkg.sv
// Shared types and constants for the 3-parallel FIR block scheduler.
// No logic, so it adds no latency.
// No flow control of its own; the types describe one block of lanes.
package fir3_pkg;

    localparam int L        = 3;
    localparam int SAMPLE_W = 32;
    localparam int RESULT_W = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [RESULT_W-1:0] result_t;
    typedef sample_t [L-1:0]            blk_t;
    typedef result_t [L-1:0]            res_blk_t;

endpackage

// File: rtl/fir3_res_fifo.sv
// Result buffer: synchronous FIFO of whole 3-lane result blocks.
// A pushed entry is visible at the head on the cycle after the push.
// No internal backpressure; the caller's credit logic must never push into a full buffer.
module fir3_res_fifo
    import fir3_pkg::*;
#(
    parameter int W     = $bits(res_blk_t),
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;

    // Storage has no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr] <= push_dat;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wr <= (r_wr == AW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
            end
            if (pop) begin
                r_rd <= (r_rd == AW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign pop_dat = r_mem[r_rd];
    assign count   = r_count;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);

    // A capture arriving while the buffer is full would lose a result.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fir3_block_scheduler.sv
// Packs 3 serial samples into a core block, strobes the core, re-serialises the 3 results.
// Latency: 3rd sample accept to first m_valid is CORE_LAT+2 cycles.
// Backpressure: blocks issue only with a free buffer credit; s_ready drops while a full block waits.
// Optional flush input (zero-pads a partial block) is enabled by defining FIR3_SCHED_FLUSH_EN.
module fir3_block_scheduler
    import fir3_pkg::*;
#(
    parameter int DW         = 32,
    parameter int YW         = 64,
    parameter int CORE_LAT   = 1,
    parameter int OBUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef FIR3_SCHED_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] core_x0,
    output logic [DW-1:0] core_x1,
    output logic [DW-1:0] core_x2,
    output logic          core_blk_en,
    input  logic [YW-1:0] core_y0,
    input  logic [YW-1:0] core_y1,
    input  logic [YW-1:0] core_y2,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [YW-1:0] m_data,
    output logic [31:0]   blk_count
);

    localparam int CW = $clog2(OBUF_DEPTH+1);

    logic [1:0]             r_idx;
    logic [L-1:0][DW-1:0]   r_col;
    logic [L-1:0][DW-1:0]   r_blk;
    logic                   r_blk_full;
    logic [L-1:0][DW-1:0]   r_core_x;
    logic                   r_core_blk_en;
    logic [CORE_LAT-1:0]    r_pipe;
    logic [31:0]            r_blk_count;
    logic [1:0]             r_out_idx;

    logic                   w_accept;
    logic                   w_issue;
    logic                   w_flush_take;
    logic                   w_load;
    logic [1:0]             w_fill;
    logic [L-1:0][DW-1:0]   w_col;
    logic [L-1:0][DW-1:0]   w_load_blk;
    logic [4:0]             w_inflight;
    logic                   w_push;
    logic                   w_pop;
    logic [L-1:0][YW-1:0]   w_push_dat;
    logic [L-1:0][YW-1:0]   w_head;
    logic [CW-1:0]          w_count;
    logic                   w_full;
    logic                   w_empty;

`ifdef FIR3_SCHED_FLUSH_EN
    assign w_flush_take = flush && (r_idx != 2'd0) && !r_blk_full;
`else
    assign w_flush_take = 1'b0;
`endif

    // Credit check: blocks in the core pipe plus buffered blocks must leave a free slot.
    always_comb begin
        w_inflight = 5'(r_core_blk_en);
        for (int i = 0; i < CORE_LAT; i++) begin
            w_inflight = w_inflight + 5'(r_pipe[i]);
        end
    end

    assign w_issue  = r_blk_full && ((w_inflight + 5'(w_count)) < 5'(OBUF_DEPTH));
    assign s_ready  = !rst && (!r_blk_full || w_issue);
    assign w_accept = s_valid && s_ready;
    assign w_fill   = r_idx + 2'(w_accept);
    assign w_load   = (w_accept && (r_idx == 2'd2)) || w_flush_take;

    // Next block contents: include this cycle's sample, zero lanes not yet filled (flush pad).
    always_comb begin
        w_col = r_col;
        if (w_accept) begin
            w_col[r_idx] = s_data;
        end
        w_load_blk = '0;
        for (int k = 0; k < L; k++) begin
            if (2'(k) < w_fill) begin
                w_load_blk[k] = w_col[k];
            end
        end
    end

    // Collector: lane index, partial lanes, and the full-block register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_col      <= '0;
            r_blk      <= '0;
            r_blk_full <= 1'b0;
        end else begin
            r_col <= w_col;
            if (w_load) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 2'd1;
            end
            // A block completing in the issue cycle keeps the flag set with new data.
            if (w_load) begin
                r_blk      <= w_load_blk;
                r_blk_full <= 1'b1;
            end else if (w_issue) begin
                r_blk_full <= 1'b0;
            end
        end
    end

    // Issue: registered one-cycle strobe with lanes, plus the issued-block counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_blk_en <= 1'b0;
            r_core_x      <= '0;
            r_blk_count   <= '0;
        end else begin
            r_core_blk_en <= w_issue;
            if (w_issue) begin
                r_core_x    <= r_blk;
                r_blk_count <= r_blk_count + 32'd1;
            end
        end
    end

    // Capture pipe: marks when the core results for an issued block become valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= r_core_blk_en;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_push     = r_pipe[CORE_LAT-1];
    assign w_push_dat = {core_y2, core_y1, core_y0};
    assign w_pop      = m_valid && m_ready && (r_out_idx == 2'd2);

    fir3_res_fifo #(
        .W     (L*YW),
        .DEPTH (OBUF_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .pop_dat  (w_head),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    // Serialiser lane pointer: walks y0, y1, y2 of the head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_idx <= '0;
        end else if (m_valid && m_ready) begin
            r_out_idx <= (r_out_idx == 2'd2) ? 2'd0 : r_out_idx + 2'd1;
        end
    end

    assign m_valid     = !w_empty;
    assign m_data      = w_empty ? '0 : w_head[r_out_idx];
    assign core_x0     = r_core_x[0];
    assign core_x1     = r_core_x[1];
    assign core_x2     = r_core_x[2];
    assign core_blk_en = r_core_blk_en;
    assign blk_count   = r_blk_count;

endmodule

// File: tb/tb_fir3_block_scheduler.sv
module tb_fir3_block_scheduler;

    localparam int DW         = 32;
    localparam int YW         = 64;
    localparam int CORE_LAT   = 1;
    localparam int OBUF_DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [DW-1:0] core_x0, core_x1, core_x2;
    logic          core_blk_en;
    logic [YW-1:0] core_y0, core_y1, core_y2;
    logic          m_valid;
    logic          m_ready;
    logic [YW-1:0] m_data;
    logic [31:0]   blk_count;
`ifdef FIR3_SCHED_FLUSH_EN
    logic          flush;
`endif

    always #5 clk = ~clk;

    fir3_block_scheduler #(
        .DW(DW), .YW(YW), .CORE_LAT(CORE_LAT), .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef FIR3_SCHED_FLUSH_EN
        .flush(flush),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_x0(core_x0), .core_x1(core_x1), .core_x2(core_x2),
        .core_blk_en(core_blk_en),
        .core_y0(core_y0), .core_y1(core_y1), .core_y2(core_y2),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .blk_count(blk_count)
    );

    function automatic logic [63:0] sx(input logic [31:0] d);
        return {{32{d[31]}}, d};
    endfunction

    // Core stub: sign-extended pass-through, results valid CORE_LAT cycles after blk_en.
    logic [YW-1:0] stub [CORE_LAT][3];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CORE_LAT; k++)
                for (int j = 0; j < 3; j++) stub[k][j] <= '0;
        end else begin
            if (core_blk_en) begin
                stub[0][0] <= sx(core_x0);
                stub[0][1] <= sx(core_x1);
                stub[0][2] <= sx(core_x2);
            end
            for (int k = 1; k < CORE_LAT; k++)
                for (int j = 0; j < 3; j++) stub[k][j] <= stub[k-1][j];
        end
    end
    assign core_y0 = stub[CORE_LAT-1][0];
    assign core_y1 = stub[CORE_LAT-1][1];
    assign core_y2 = stub[CORE_LAT-1][2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: samples group into blocks of 3 in arrival order; outputs equal inputs.
    logic [31:0] col_q [$];
    logic [95:0] exp_blk [$];
    logic [63:0] exp_out [$];
    int          model_blocks = 0;

    function automatic void close_block();
        exp_blk.push_back({col_q[2], col_q[1], col_q[0]});
        for (int i = 0; i < 3; i++) exp_out.push_back(sx(col_q[i]));
        model_blocks++;
        col_q.delete();
    endfunction

    function automatic void model_accept(input logic [31:0] d);
        col_q.push_back(d);
        if (col_q.size() == 3) close_block();
    endfunction

`ifdef FIR3_SCHED_FLUSH_EN
    function automatic void model_flush();
        if (col_q.size() != 0) begin
            while (col_q.size() < 3) col_q.push_back(32'd0);
            close_block();
        end
    endfunction
`endif

    function automatic void model_reset();
        col_q.delete();
        exp_blk.delete();
        exp_out.delete();
        model_blocks = 0;
    endfunction

    // Monitors: block lanes, output scoreboard, and hold-while-stalled.
    bit          stall_prev = 0;
    logic [63:0] stall_dat;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (core_blk_en) begin
                if (exp_blk.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL blk_unexpected: got lanes %0h, expected no block", {core_x2, core_x1, core_x0});
                end else begin
                    check("blk_lanes", {core_x2, core_x1, core_x0}, exp_blk.pop_front());
                end
            end
            if (stall_prev) begin
                check("hold_valid", 96'(m_valid), 96'(1));
                check("hold_data", 96'(m_data), 96'(stall_dat));
            end
            if (m_valid && m_ready) begin
                if (exp_out.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out_unexpected: got %0h, expected no output", m_data);
                end else begin
                    check("m_data", 96'(m_data), 96'(exp_out.pop_front()));
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_dat  = m_data;
        end
    end

    bit rand_ready = 0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(input logic [31:0] d, output int acc_cyc, output bit waited);
        bit got;
        got     = 0;
        waited  = 0;
        acc_cyc = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1;
            else waited = 1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: s_ready stayed 0, expected accept of %0h", d);
        end else begin
            model_accept(d);
            acc_cyc = cyc;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500 && (exp_out.size() != 0 || exp_blk.size() != 0); i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check(name, 96'(exp_out.size() + exp_blk.size()), 96'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        bit  waited;
        int  lat;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef FIR3_SCHED_FLUSH_EN
        flush   = 1'b0;
`endif
        #3;
        check("rst_s_ready", 96'(s_ready), 96'(0));
        check("rst_m_valid", 96'(m_valid), 96'(0));
        check("rst_m_data", 96'(m_data), 96'(0));
        check("rst_blk_count", 96'(blk_count), 96'(0));
        check("rst_blk_en", 96'(core_blk_en), 96'(0));
        check("rst_core_x", {core_x2, core_x1, core_x0}, 96'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single block with latency measurement and a stall on lane 1.
        send(32'd5, acc, waited);
        send(-32'sd7, acc, waited);
        send(32'd9, acc, waited);
        lat = -1;
        for (int i = 0; i < 30 && lat < 0; i++) begin
            @(negedge clk);
            if (m_valid) lat = cyc - acc - 1;
        end
        check("first_latency", 96'(lat), 96'(CORE_LAT + 2));
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b1;
        drain("single_drain");
        check("single_blk_count", 96'(blk_count), 96'(model_blocks));

        // Streaming: back-to-back samples, s_ready must not drop.
        for (int i = 0; i < 300; i++) begin
            send(32'(i), acc, waited);
            if (i >= 3) check("stream_ready", 96'(waited), 96'(0));
        end
        drain("stream_drain");
        check("stream_blk_count", 96'(blk_count), 96'(model_blocks));

        // Backpressure: downstream stalled, only OBUF_DEPTH blocks issue.
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(32'(1000 + i), acc, waited);
        s_valid = 1'b1;
        s_data  = 32'd1009;
        repeat (10) @(negedge clk);
        check("bp_s_ready", 96'(s_ready), 96'(0));
        check("bp_blk_count", 96'(blk_count), 96'(model_blocks - 1));
        @(posedge clk); #1 m_ready = 1'b1;
        for (int i = 9; i < 12; i++) send(32'(1000 + i), acc, waited);
        drain("bp_drain");
        check("bp_blk_count_end", 96'(blk_count), 96'(model_blocks));

        // Random data with random downstream readiness.
        rand_ready = 1;
        for (int i = 0; i < 60; i++) send($urandom, acc, waited);
        rand_ready = 0;
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;
        drain("rand_drain");
        check("rand_blk_count", 96'(blk_count), 96'(model_blocks));

        // Reset with one result buffered and a partial block collected.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(77 + i), acc, waited);
        repeat (6) @(posedge clk);
        #1;
        send(32'd500, acc, waited);
        send(32'd501, acc, waited);
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 96'(m_valid), 96'(0));
        check("mid_rst_blk_count", 96'(blk_count), 96'(0));
        check("mid_rst_s_ready", 96'(s_ready), 96'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ready = 1'b1;
        send(32'd1, acc, waited);
        send(32'd2, acc, waited);
        send(32'd3, acc, waited);
        drain("post_rst_drain");
        check("post_rst_blk_count", 96'(blk_count), 96'(model_blocks));

`ifdef FIR3_SCHED_FLUSH_EN
        // Flush pads a two-sample partial block with a zero lane.
        send(32'd4, acc, waited);
        send(32'd8, acc, waited);
        flush = 1'b1;
        model_flush();
        @(posedge clk); #1 flush = 1'b0;
        drain("flush_drain");
        check("flush_blk_count", 96'(blk_count), 96'(model_blocks));
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
